// File: rtl/mdu_pkg.sv
// Shared CPU definitions: ALU and multiply/divide opcodes plus the default
// multiply/divide latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing the HI/LO result for one op.
// Division works on magnitudes so the INT_MIN / -1 case falls out without overflow.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next
);

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        b_div;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign is_signed = (mdu_op_e'(op) == MDU_DIV);
  assign a_neg     = is_signed & a[31];
  assign b_neg     = is_signed & b[31];
  assign a_mag     = a_neg ? (~a + 32'd1) : a;
  assign b_mag     = b_neg ? (~b + 32'd1) : b;
  // A zero divisor is replaced so the divider never sees it; the result is discarded.
  assign b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag     = a_mag / b_div;
  assign r_mag     = a_mag % b_div;

  always_comb begin
    hi_next = 32'd0;
    lo_next = 32'd0;
    case (mdu_op_e'(op))
      MDU_MULT:  {hi_next, lo_next} = prod_s;
      MDU_MULTU: {hi_next, lo_next} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        lo_next = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        hi_next = a_neg ? (~r_mag + 32'd1) : r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: computes at issue, holds the result for a
// fixed latency while busy, then commits it to the architectural HI/LO pair.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      hi_n, lo_n;
  logic [31:0]      hi_t, lo_t, hi_t_n, lo_t_n;
  logic             commit_t, commit_t_n;
  logic [31:0]      calc_hi, calc_lo;

  mdu_calc u_calc (
    .a       (A),
    .b       (B),
    .op      (mdu_op),
    .hi_next (calc_hi),
    .lo_next (calc_lo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      hi_t     <= 32'd0;
      lo_t     <= 32'd0;
      commit_t <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hi       <= hi_n;
      lo       <= lo_n;
      hi_t     <= hi_t_n;
      lo_t     <= lo_t_n;
      commit_t <= commit_t_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    hi_n       = hi;
    lo_n       = lo;
    hi_t_n     = hi_t;
    lo_t_n     = lo_t;
    commit_t_n = commit_t;
    case (state)
      IDLE: begin
        if (start) begin
          case (mdu_op_e'(mdu_op))
            MDU_MULT, MDU_MULTU: begin
              hi_t_n     = calc_hi;
              lo_t_n     = calc_lo;
              commit_t_n = 1'b1;
              cnt_n      = CNT_W'(MULT_CYCLES);
              state_n    = BUSY;
            end
            MDU_DIV, MDU_DIVU: begin
              hi_t_n     = calc_hi;
              lo_t_n     = calc_lo;
              // Divide by zero still occupies the unit but leaves HI/LO untouched.
              commit_t_n = (B != 32'd0);
              cnt_n      = CNT_W'(DIV_CYCLES);
              state_n    = BUSY;
            end
            MDU_MTHI: hi_n = A;
            MDU_MTLO: lo_n = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          if (commit_t) begin
            hi_n = hi_t;
            lo_n = lo_t;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_mdu.sv
// Directed bench for the multiply/divide unit with hand-computed HI/LO results.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int nchk = 0;
  int nerr = 0;
  int ncyc;
  int seen;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mdu_op  (mdu_op),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue one op for a single cycle, then count busy cycles until idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    start = 1'b1; mdu_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; mdu_op = 3'd0; A = 32'd0; B = 32'd0;
    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); reset_n = 1'b1;

    run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, ncyc);
    chk("mult_cycles", ncyc, 5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    // MULTU with a second start while busy that must be dropped
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULTU; A = 32'hFFFFFFFF; B = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("multu_busy", busy, 1);
    ncyc = 0;
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_DIV; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; ncyc++;
    chk("hold_hi", hi, 32'hFFFFFFFF);
    chk("hold_lo", lo, 32'hFFFFFFFA);
    while (busy && ncyc < 100) begin
      @(posedge clk); #1;
      ncyc++;
    end
    chk("multu_cycles", ncyc, 5);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (busy) seen++;
    end
    chk("no_queue_busy", seen, 0);
    chk("no_queue_hi", hi, 32'd1);
    chk("no_queue_lo", lo, 32'hFFFFFFFE);

    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, ncyc);
    chk("div_cycles", ncyc, 10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    run_op(MDU_DIVU, 32'd7, 32'd2, ncyc);
    chk("divu_cycles", ncyc, 10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    run_op(MDU_MTHI, 32'h11, 32'd0, ncyc);
    chk("mthi_busy", ncyc, 0);
    run_op(MDU_MTLO, 32'h22, 32'd0, ncyc);
    chk("mtlo_busy", ncyc, 0);
    chk("mt_hi", hi, 32'h11);
    chk("mt_lo", lo, 32'h22);

    run_op(MDU_DIVU, 32'd5, 32'd0, ncyc);
    chk("div0_cycles", ncyc, 10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    run_op(3'd7, 32'hDEADBEEF, 32'd3, ncyc);
    chk("undef_busy", ncyc, 0);
    chk("undef_hi", hi, 32'h11);
    chk("undef_lo", lo, 32'h22);

    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, ncyc);
    chk("ovf_cycles", ncyc, 10);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'd0);

    // Reset asserted in the fourth busy cycle of a DIV
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_DIV; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    repeat (12) @(posedge clk);
    #3;
    reset_n = 1'b1;
    chk("abort_late_lo", lo, 0);

    run_op(MDU_MULT, 32'd7, 32'd6, ncyc);
    chk("post_rst_cycles", ncyc, 5);
    chk("post_rst_lo", lo, 32'd42);
    chk("post_rst_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, sets the busy duration of MULT and MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, sets the busy duration of DIV and DIVU.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on the rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: an EX-stage mult/div instruction is valid this cycle.
REQ-006 Port mdu_op, input, 3 bits: selects MULT, MULTU, DIV, DIVU, MTHI or MTLO.
REQ-007 Port A, input, 32 bits: forwarded rs operand, the same source that drives ALU input A.
REQ-008 Port B, input, 32 bits: forwarded rt operand, the same source that drives ALU input B.
REQ-009 Port busy, output, 1 bit: an operation is in flight.
REQ-010 Port hi, output, 32 bits: architectural HI register.
REQ-011 Port lo, output, 32 bits: architectural LO register.

Function
REQ-012 The block SHALL have two states, IDLE and BUSY, with counter cnt wide enough to hold DIV_CYCLES.
REQ-013 In IDLE with start=1 and mdu_op MULT, MULTU, DIV or DIVU, the block SHALL latch the operation result into temporary registers, load cnt with the matching *_CYCLES value, and enter BUSY on the next edge.
REQ-014 busy SHALL be 1 for exactly MULT_CYCLES or DIV_CYCLES consecutive cycles, starting the cycle after start.
REQ-015 Each BUSY cycle SHALL decrement cnt; at cnt==1 the next edge SHALL write hi and lo from the temporaries, clear busy and return to IDLE.
REQ-016 hi and lo SHALL hold their old values while busy=1 and SHALL show the new result in the same cycle busy falls.
REQ-017 MULT SHALL compute the signed 64-bit product {hi,lo}=A*B; MULTU SHALL compute the unsigned product.
REQ-018 DIV SHALL compute the signed quotient truncated toward zero into lo and the remainder into hi, with the remainder taking the sign of the dividend; DIVU SHALL do the same with unsigned operands.
REQ-019 For DIV or DIVU with B==0, hi and lo SHALL remain unchanged, but busy SHALL still run for DIV_CYCLES.
REQ-020 For DIV with A=0x80000000 and B=0xFFFFFFFF, the result SHALL be lo=0x80000000 and hi=0.
REQ-021 In IDLE with start=1, MTHI SHALL write hi<=A and MTLO SHALL write lo<=A on the next edge, and busy SHALL stay 0.
REQ-022 start SHALL be ignored while busy=1; the hazard unit stalls the pipeline on (start & mult/div op) | busy, and the block SHALL NOT queue any operation.
REQ-023 An undefined mdu_op with start=1 SHALL change no state.
REQ-024 Assertion of reset_n=0 during BUSY SHALL abort the operation with no HI/LO commit.

Reset
REQ-025 While reset_n=0, and independent of clk: hi=0, lo=0, busy=0, cnt=0, state=IDLE, temporaries=0.
REQ-026 The first edge after reset_n rises SHALL accept start normally.

Structure
REQ-027 The mdu_op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5) and the default cycle counts SHALL live in the shared CPU definitions package alongside the ALU opcode definitions.
REQ-028 The arithmetic SHALL be one combinational sub-module, mdu_calc (A, B, op -> hi_next, lo_next); the control FSM and counter SHALL stay in mdu.
REQ-029 The intended implementation size is 120-250 lines of RTL.

Verification
REQ-030 Signed multiply: MULT with A=0xFFFFFFFE (-2) and B=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-031 Unsigned multiply and back-to-back start: MULTU with A=0xFFFFFFFF and B=2 -> hi=1 and lo=0xFFFFFFFE; a start issued during busy is ignored, leaving hi and lo unchanged.
REQ-032 Signed divide: DIV with A=-7 and B=2 -> after 10 busy cycles, lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU with A=7 and B=2 -> lo=3 and hi=1.
REQ-033 Divide by zero: preload hi=0x11 and lo=0x22 via MTHI/MTLO (busy never rises), then DIVU with B=0 -> busy for 10 cycles, and hi/lo remain 0x11 and 0x22.
REQ-034 Reset mid-operation: DIV with A=100 and B=7, then reset_n=0 in busy cycle 4 -> hi=0, lo=0 and busy=0 immediately, with no later commit.
REQ-035 Overflow divide: DIV with A=0x80000000 and B=0xFFFFFFFF -> lo=0x80000000 and hi=0.
